// File: rtl/crc32_pol4_check_if.sv
// Stream and result handshake bundle for the CRC32 frame checker.
// master = traffic source / result sink, slave = checker.
interface crc32_pol4_check_if #(
  parameter int LEN_W = 16
);
  logic [7:0]       data_i;
  logic             valid_i;
  logic             sop_i;
  logic             eop_i;
  logic             ready_o;
  logic             res_valid_o;
  logic             res_ready_i;
  logic             res_ok_o;
  logic             res_short_o;
  logic             res_ovf_o;
  logic [LEN_W-1:0] res_len_o;
  logic [31:0]      res_crc_o;
  logic [31:0]      res_rcv_crc_o;

  modport master (
    output data_i, valid_i, sop_i, eop_i, res_ready_i,
    input  ready_o, res_valid_o, res_ok_o, res_short_o, res_ovf_o,
           res_len_o, res_crc_o, res_rcv_crc_o
  );

  modport slave (
    input  data_i, valid_i, sop_i, eop_i, res_ready_i,
    output ready_o, res_valid_o, res_ok_o, res_short_o, res_ovf_o,
           res_len_o, res_crc_o, res_rcv_crc_o
  );
endinterface

// File: rtl/crc32_pol4_check.sv
// Byte-serial CRC32 (poly 0x1EDC6F41, MSB-first, no final XOR) frame checker.
// The last 4 bytes of each packet are the big-endian CRC trailer.
//
// state  | meaning
// S_IDLE | waiting for a sop beat; non-sop beats are accepted and dropped
// S_PKT  | collecting packet bytes
// S_RES  | result held on res_*, waiting for res_ready_i
module crc32_pol4_check #(
  parameter int          LEN_W = 16,
  parameter logic [31:0] INIT  = 32'hFFFF_FFFF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  crc32_pol4_check_if.slave  bus
);

  localparam logic [31:0]      POLY    = 32'h1EDC_6F41;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_RES} state_e;

  function automatic logic [31:0] next8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = (r << 1) ^ POLY;
      else              r = r << 1;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [3:0][7:0]  dl_q, dl_d;
  logic [2:0]       held_q, held_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic             res_ok_q, res_ok_d;
  logic             res_short_q, res_short_d;
  logic             res_ovf_q, res_ovf_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;
  logic [31:0]      res_crc_q, res_crc_d;
  logic [31:0]      res_rcv_q, res_rcv_d;

  logic ready;
  logic accept;
  logic start;
  logic cont;
  logic short_pkt;

  always_comb begin
    state_d     = state_q;
    dl_d        = dl_q;
    held_d      = held_q;
    crc_d       = crc_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    res_ok_d    = res_ok_q;
    res_short_d = res_short_q;
    res_ovf_d   = res_ovf_q;
    res_len_d   = res_len_q;
    res_crc_d   = res_crc_q;
    res_rcv_d   = res_rcv_q;
    short_pkt   = 1'b0;

    ready  = !rst_i && (state_q != S_RES || bus.res_ready_i);
    accept = bus.valid_i && ready;
    start  = accept && bus.sop_i;
    cont   = accept && !bus.sop_i && (state_q == S_PKT);

    if (state_q == S_RES && bus.res_ready_i) state_d = S_IDLE;

    if (start) begin
      crc_d  = INIT;
      len_d  = '0;
      ovf_d  = 1'b0;
      held_d = 3'd1;
      dl_d   = {24'h0, bus.data_i};
    end else if (cont) begin
      // The oldest held byte is payload once four newer bytes exist behind it.
      if (held_q == 3'd4) begin
        crc_d = next8(crc_q, dl_q[3]);
        if (len_q == LEN_MAX) ovf_d = 1'b1;
        else                  len_d = len_q + 1'b1;
      end else begin
        held_d = held_q + 3'd1;
      end
      dl_d = {dl_q[2:0], bus.data_i};
    end

    if (start || cont) begin
      state_d = bus.eop_i ? S_RES : S_PKT;
      if (bus.eop_i) begin
        short_pkt   = (held_d != 3'd4);
        res_short_d = short_pkt;
        res_rcv_d   = dl_d;
        res_crc_d   = short_pkt ? INIT : crc_d;
        res_len_d   = short_pkt ? '0 : len_d;
        res_ovf_d   = ovf_d;
        res_ok_d    = !short_pkt && (crc_d == dl_d);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      dl_q        <= '0;
      held_q      <= '0;
      crc_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      res_ok_q    <= 1'b0;
      res_short_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_len_q   <= '0;
      res_crc_q   <= '0;
      res_rcv_q   <= '0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      held_q      <= held_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      res_ok_q    <= res_ok_d;
      res_short_q <= res_short_d;
      res_ovf_q   <= res_ovf_d;
      res_len_q   <= res_len_d;
      res_crc_q   <= res_crc_d;
      res_rcv_q   <= res_rcv_d;
    end
  end

  assign bus.ready_o       = ready;
  assign bus.res_valid_o   = (state_q == S_RES);
  assign bus.res_ok_o      = res_ok_q;
  assign bus.res_short_o   = res_short_q;
  assign bus.res_ovf_o     = res_ovf_q;
  assign bus.res_len_o     = res_len_q;
  assign bus.res_crc_o     = res_crc_q;
  assign bus.res_rcv_crc_o = res_rcv_q;

endmodule

// File: tb/tb_crc32_pol4_check.sv
// Scoreboard bench for crc32_pol4_check; a LEN_W=16 and a LEN_W=4 instance
// see identical traffic so the length saturation path is exercised too.
module tb_crc32_pol4_check;

  localparam logic [31:0] POLY = 32'h1EDC_6F41;
  localparam logic [31:0] INIT = 32'hFFFF_FFFF;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic        ok;
    logic        short_p;
    logic        ovf16;
    logic        ovf4;
    logic [15:0] len16;
    logic [3:0]  len4;
    logic [31:0] crc;
    logic [31:0] rcv;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0, sop = 1'b0, eop = 1'b0;
  logic       rr_fixed = 1'b1, rr_rand = 1'b0, rr_bit = 1'b1;
  logic       res_ready;

  always #5 clk = ~clk;
  assign res_ready = rr_rand ? rr_bit : rr_fixed;

  crc32_pol4_check_if #(.LEN_W(16)) bus16 ();
  crc32_pol4_check_if #(.LEN_W(4))  bus4 ();

  assign bus16.data_i = data;  assign bus4.data_i = data;
  assign bus16.valid_i = valid; assign bus4.valid_i = valid;
  assign bus16.sop_i = sop;    assign bus4.sop_i = sop;
  assign bus16.eop_i = eop;    assign bus4.eop_i = eop;
  assign bus16.res_ready_i = res_ready;
  assign bus4.res_ready_i  = res_ready;

  crc32_pol4_check #(.LEN_W(16), .INIT(INIT)) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus16));
  crc32_pol4_check #(.LEN_W(4),  .INIT(INIT)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));

  int   checks = 0;
  int   failures = 0;
  int   stalls = 0;
  int   nres = 0;
  exp_t exp_q[$];

  logic        l_ok, l_short, l_ovf, l4_ok, l4_ovf;
  logic [15:0] l_len;
  logic [3:0]  l4_len;
  logic [31:0] l_crc, l_rcv;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input byte_q_t b, input int n);
    logic [31:0] c;
    c = INIT;
    for (int k = 0; k < n; k++) begin
      c ^= {b[k], 24'h0};
      for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  function automatic exp_t model(input byte_q_t b);
    exp_t e;
    int   n, p;
    n = b.size();
    e = '{default: '0};
    e.crc = INIT;
    if (n < 4) begin
      e.short_p = 1'b1;
      for (int k = 0; k < n; k++) e.rcv = {e.rcv[23:0], b[k]};
    end else begin
      p       = n - 4;
      e.crc   = crc_model(b, p);
      e.rcv   = {b[n-4], b[n-3], b[n-2], b[n-1]};
      e.ok    = (e.crc == e.rcv);
      e.len16 = (p > 65535) ? 16'hFFFF : 16'(p);
      e.ovf16 = (p > 65535);
      e.len4  = (p > 15) ? 4'hF : 4'(p);
      e.ovf4  = (p > 15);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #2 rr_bit = 1'($urandom_range(1));
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus16.res_valid_o) begin
      chk("valid_match4", bus4.res_valid_o, 1'b1);
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1'b1, 1'b0);
      end else begin
        e = exp_q[0];
        chk("ok",      bus16.res_ok_o,      e.ok);
        chk("short",   bus16.res_short_o,   e.short_p);
        chk("ovf",     bus16.res_ovf_o,     e.ovf16);
        chk("len",     bus16.res_len_o,     e.len16);
        chk("crc",     bus16.res_crc_o,     e.crc);
        chk("rcv_crc", bus16.res_rcv_crc_o, e.rcv);
        chk("ok4",     bus4.res_ok_o,       e.ok);
        chk("ovf4",    bus4.res_ovf_o,      e.ovf4);
        chk("len4",    bus4.res_len_o,      e.len4);
        chk("crc4",    bus4.res_crc_o,      e.crc);
        if (res_ready) begin
          void'(exp_q.pop_front());
          nres++;
          l_ok = bus16.res_ok_o; l_short = bus16.res_short_o; l_ovf = bus16.res_ovf_o;
          l_len = bus16.res_len_o; l_crc = bus16.res_crc_o; l_rcv = bus16.res_rcv_crc_o;
          l4_ok = bus4.res_ok_o; l4_ovf = bus4.res_ovf_o; l4_len = bus4.res_len_o;
        end
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b, input logic s, input logic e);
    int   guard;
    logic acc;
    guard = 0;
    data = b; valid = 1'b1; sop = s; eop = e;
    do begin
      @(negedge clk);
      acc = bus16.ready_o;
      if (!acc) stalls++;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 1000);
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  task automatic send_pkt(input byte_q_t b, input int gap_pct, input bit abort);
    int n;
    n = b.size();
    for (int k = 0; k < n; k++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        @(posedge clk); #1;
      end
      drive_byte(b[k], k == 0, !abort && k == n - 1);
    end
    if (!abort) exp_q.push_back(model(b));
  endtask

  task automatic wait_res(input int target);
    int g;
    g = 0;
    while (nres < target && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("result_timeout", nres >= target, 1'b1);
  endtask

  task automatic good_pkt(input int plen, output byte_q_t b);
    logic [31:0] c;
    b = {};
    for (int k = 0; k < plen; k++) b.push_back(8'($urandom));
    c = crc_model(b, plen);
    b.push_back(c[31:24]); b.push_back(c[23:16]);
    b.push_back(c[15:8]);  b.push_back(c[7:0]);
  endtask

  initial begin
    byte_q_t b, b2;
    int      n0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus16.ready_o, 1'b0);
    chk("rst_res_valid", bus16.res_valid_o, 1'b0);
    chk("rst_res_fields", {bus16.res_ok_o, bus16.res_short_o, bus16.res_ovf_o,
                           bus16.res_len_o, bus16.res_crc_o}, 51'h0);
    chk("rst_rcv_crc", bus16.res_rcv_crc_o, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus16.ready_o, 1'b1);
    @(posedge clk); #1;

    b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_pkt(b, 0, 0); wait_res(1);
    chk("empty_ok", l_ok, 1'b1);
    chk("empty_len", l_len, 16'd0);
    chk("empty_crc", l_crc, 32'hFFFF_FFFF);

    b = '{8'h00, 8'h75, 8'h35, 8'h41, 8'hB5};
    send_pkt(b, 0, 0);
    chk("latency_valid", bus16.res_valid_o, 1'b1);
    wait_res(2);
    chk("one_ok", l_ok, 1'b1);
    chk("one_len", l_len, 16'd1);
    chk("one_crc", l_crc, 32'h7535_41B5);
    chk("one_rcv", l_rcv, 32'h7535_41B5);

    b = '{8'h00, 8'h75, 8'h35, 8'h41, 8'hB4};
    send_pkt(b, 0, 0); wait_res(3);
    chk("bad_ok", l_ok, 1'b0);
    chk("bad_crc", l_crc, 32'h7535_41B5);
    chk("bad_rcv", l_rcv, 32'h7535_41B4);

    b = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(b, 0, 0); wait_res(4);
    chk("short_flag", l_short, 1'b1);
    chk("short_ok", l_ok, 1'b0);
    chk("short_len", l_len, 16'd0);
    chk("short_rcv", l_rcv, 32'h00AA_BBCC);
    chk("short_crc", l_crc, INIT);

    rr_fixed = 1'b0;
    b = '{8'h00, 8'h75, 8'h35, 8'h41, 8'hB5};
    send_pkt(b, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", bus16.ready_o, 1'b0);
      chk("bp_valid", bus16.res_valid_o, 1'b1);
      chk("bp_crc_stable", bus16.res_crc_o, 32'h7535_41B5);
      chk("bp_ok_stable", bus16.res_ok_o, 1'b1);
    end
    @(posedge clk); #1 rr_fixed = 1'b1;
    wait_res(5);

    stalls = 0;
    good_pkt(6, b); good_pkt(3, b2);
    send_pkt(b, 0, 0); send_pkt(b2, 0, 0);
    chk("no_bubble", stalls, 0);
    wait_res(7);

    good_pkt(4, b); send_pkt(b, 0, 1);
    good_pkt(5, b2); send_pkt(b2, 0, 0);
    wait_res(8);
    chk("abort_ok", l_ok, 1'b1);
    chk("abort_len", l_len, 16'd5);

    b = '{8'h11, 8'h22, 8'h33};
    send_pkt(b, 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", bus16.ready_o, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    drive_byte(8'h55, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_result", bus16.res_valid_o, 1'b0);
    end
    @(posedge clk); #1;

    good_pkt(30, b);
    send_pkt(b, 0, 0); wait_res(9);
    chk("ovf4_len", l4_len, 4'hF);
    chk("ovf4_flag", l4_ovf, 1'b1);
    chk("ovf4_ok", l4_ok, 1'b1);
    chk("ovf16_len", l_len, 16'd30);
    chk("ovf16_flag", l_ovf, 1'b0);

    rr_rand = 1'b1;
    n0 = nres;
    for (int p = 0; p < 25; p++) begin
      if (p % 2 == 0) good_pkt($urandom_range(36), b);
      else begin
        b = {};
        for (int k = 0; k < int'($urandom_range(40, 1)); k++) b.push_back(8'($urandom));
      end
      send_pkt(b, 30, 0);
    end
    wait_res(n0 + 25);
    rr_rand = 1'b0;
    repeat (3) @(posedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
